// File: rtl/pi1_to_wb4_wrbuf.sv
// pi1_to_wb4_wrbuf
//   Bridges a PI1 master onto a pipelined Wishbone B4 slave. Writes are posted
//   into a small FIFO and drained in order. Reads and read-then-write (RW) wait
//   until that FIFO is empty, so they never overtake a posted write.
//   At most one wb4 transaction is in flight at a time.
//
// Parameters
//   ARCHBITSZ     data width (16/32/64/128/256)
//   WRBUFDEPTH    posted-write entries (power of two, >= 2)
//   TIMEOUTCYCLES ack timeout, used only with PI1_TO_WB4_WRBUF_TIMEOUT_EN
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   pi1_op_i                     00 nop, 01 write, 10 read, 11 read-then-write
//   pi1_addr_i                   word address
//   pi1_data_i / pi1_data_o      write data / read data (0 when nothing completes)
//   pi1_sel_i                    byte enables
//   pi1_rdy_o                    op accepted / read completes this cycle
//   wb4_cyc_o/stb_o/we_o         wb4 cycle controls
//   wb4_addr_o                   byte address
//   wb4_data_o/sel_o             write data / byte enables
//   wb4_stall_i/ack_i/data_i     wb4 slave responses
//
// Build option
//   PI1_TO_WB4_WRBUF_TIMEOUT_EN  abort a wb4 transaction with no ack after
//                                TIMEOUTCYCLES cycles; reads then return all-ones.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | accepting ops; draining posted writes
// S_RDPEND | read/RW latched, draining FIFO before the read is issued
// S_RD     | wb4 read outstanding
// S_RWWR   | write phase of RW outstanding (cyc held since the read)
module pi1_to_wb4_wrbuf #(
  parameter int ARCHBITSZ     = 32,
  parameter int WRBUFDEPTH    = 4,
  parameter int TIMEOUTCYCLES = 255
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  input  logic [1:0]                                  pi1_op_i,
  input  logic [ARCHBITSZ-$clog2(ARCHBITSZ/8)-1:0]    pi1_addr_i,
  input  logic [ARCHBITSZ-1:0]                        pi1_data_i,
  output logic [ARCHBITSZ-1:0]                        pi1_data_o,
  input  logic [ARCHBITSZ/8-1:0]                      pi1_sel_i,
  output logic                                        pi1_rdy_o,
  output logic                                        wb4_cyc_o,
  output logic                                        wb4_stb_o,
  output logic                                        wb4_we_o,
  output logic [ARCHBITSZ-1:0]                        wb4_addr_o,
  output logic [ARCHBITSZ-1:0]                        wb4_data_o,
  output logic [ARCHBITSZ/8-1:0]                      wb4_sel_o,
  input  logic                                        wb4_stall_i,
  input  logic                                        wb4_ack_i,
  input  logic [ARCHBITSZ-1:0]                        wb4_data_i
);

  localparam int SELW = ARCHBITSZ / 8;
  localparam int OFFW = $clog2(SELW);
  localparam int PTRW = $clog2(WRBUFDEPTH);
  localparam int CNTW = $clog2(WRBUFDEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RDPEND, S_RD, S_RWWR} state_t;

  state_t                state_q, state_d;
  logic                  cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [ARCHBITSZ-1:0]  addr_q, addr_d, wdat_q, wdat_d;
  logic [SELW-1:0]       sel_q, sel_d;
  logic                  lat_rw_q, lat_rw_d;
  logic [ARCHBITSZ-1:0]  lat_addr_q, lat_addr_d, lat_data_q, lat_data_d;
  logic [SELW-1:0]       lat_sel_q, lat_sel_d;
  logic [ARCHBITSZ-1:0]  rdat_q, rdat_d;
  logic [ARCHBITSZ-1:0]  pdata;
  logic                  accept, rdy, push, pop, ack, tmo;

  logic [OFFW-1:0]       boff;
  logic [ARCHBITSZ-1:0]  byte_addr;

  logic [ARCHBITSZ-1:0]  buf_addr [WRBUFDEPTH];
  logic [ARCHBITSZ-1:0]  buf_data [WRBUFDEPTH];
  logic [SELW-1:0]       buf_sel  [WRBUFDEPTH];
  logic [PTRW-1:0]       wr_ptr, rd_ptr;
  logic [CNTW-1:0]       count, count_d;
  logic                  full, empty;

  // Low address bits come from the lowest enabled byte lane.
  always_comb begin
    boff = '0;
    for (int i = SELW - 1; i >= 0; i--) begin
      if (pi1_sel_i[i]) boff = OFFW'(i);
    end
  end
  assign byte_addr = {pi1_addr_i, boff};

  // Acks arriving outside a cycle are not ours.
  assign ack = wb4_ack_i && cyc_q;

`ifdef PI1_TO_WB4_WRBUF_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUTCYCLES + 1);
  logic [TW-1:0] tmo_cnt;
  logic          tmo_load;

  // Reload on every new wb4 phase, including the write half of an RW.
  assign tmo_load = (cyc_d && !cyc_q) || (state_q == S_RD && state_d == S_RWWR);
  assign tmo      = cyc_q && !ack && (tmo_cnt == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i)                         tmo_cnt <= '0;
    else if (tmo_load)                 tmo_cnt <= TW'(TIMEOUTCYCLES - 1);
    else if (cyc_q && tmo_cnt != '0)   tmo_cnt <= tmo_cnt - 1'b1;
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    stb_d      = stb_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdat_d     = wdat_q;
    sel_d      = sel_q;
    lat_rw_d   = lat_rw_q;
    lat_addr_d = lat_addr_q;
    lat_data_d = lat_data_q;
    lat_sel_d  = lat_sel_q;
    rdat_d     = rdat_q;
    pdata      = '0;
    accept     = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;

    if (cyc_q && stb_q && !wb4_stall_i) stb_d = 1'b0;

    case (state_q)
      S_IDLE, S_RDPEND: begin
        accept = (state_q == S_IDLE) && !full;
        if (cyc_q && (ack || tmo)) begin
          cyc_d = 1'b0;
          stb_d = 1'b0;
          we_d  = 1'b0;
          pop   = 1'b1;
        end else if (!cyc_q && !empty) begin
          cyc_d  = 1'b1;
          stb_d  = 1'b1;
          we_d   = 1'b1;
          addr_d = buf_addr[rd_ptr];
          wdat_d = buf_data[rd_ptr];
          sel_d  = buf_sel[rd_ptr];
        end else if (state_q == S_RDPEND && !cyc_q) begin
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = lat_addr_q;
          sel_d   = lat_sel_q;
          state_d = S_RD;
        end
      end
      S_RD: begin
        if (ack && lat_rw_q) begin
          rdat_d  = wb4_data_i;
          stb_d   = 1'b1;
          we_d    = 1'b1;
          wdat_d  = lat_data_q;
          state_d = S_RWWR;
        end else if (ack || tmo) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          pdata   = ack ? wb4_data_i : '1;
          accept  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_RWWR: begin
        if (ack || tmo) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          pdata   = ack ? rdat_q : '1;
          accept  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    rdy = accept && !rst_i;

    if (rdy) begin
      case (pi1_op_i)
        2'b01: push = 1'b1;
        2'b10, 2'b11: begin
          lat_rw_d   = pi1_op_i[0];
          lat_addr_d = byte_addr;
          lat_data_d = pi1_data_i;
          lat_sel_d  = pi1_sel_i;
          state_d    = S_RDPEND;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdat_q     <= '0;
      sel_q      <= '0;
      lat_rw_q   <= 1'b0;
      lat_addr_q <= '0;
      lat_data_q <= '0;
      lat_sel_q  <= '0;
      rdat_q     <= '0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      stb_q      <= stb_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdat_q     <= wdat_d;
      sel_q      <= sel_d;
      lat_rw_q   <= lat_rw_d;
      lat_addr_q <= lat_addr_d;
      lat_data_q <= lat_data_d;
      lat_sel_q  <= lat_sel_d;
      rdat_q     <= rdat_d;
    end
  end

  // Posted-write FIFO
  assign count_d = count + CNTW'(push) - CNTW'(pop);

  always_ff @(posedge clk_i) begin
    if (push) begin
      buf_addr[wr_ptr] <= byte_addr;
      buf_data[wr_ptr] <= pi1_data_i;
      buf_sel[wr_ptr]  <= pi1_sel_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_d;
      full  <= (count_d == CNTW'(WRBUFDEPTH));
      empty <= (count_d == '0);
    end
  end

  assign pi1_rdy_o  = rdy;
  assign pi1_data_o = rst_i ? '0 : pdata;
  assign wb4_cyc_o  = cyc_q;
  assign wb4_stb_o  = stb_q;
  assign wb4_we_o   = we_q;
  assign wb4_addr_o = addr_q;
  assign wb4_data_o = wdat_q;
  assign wb4_sel_o  = sel_q;

endmodule

// File: tb/tb_pi1_to_wb4_wrbuf.sv
module tb_pi1_to_wb4_wrbuf;

  logic        clk;
  logic        rst_i;
  logic [1:0]  pi1_op_i;
  logic [29:0] pi1_addr_i;
  logic [31:0] pi1_data_i;
  logic [31:0] pi1_data_o;
  logic [3:0]  pi1_sel_i;
  logic        pi1_rdy_o;
  logic        wb4_cyc_o, wb4_stb_o, wb4_we_o;
  logic [31:0] wb4_addr_o, wb4_data_o;
  logic [3:0]  wb4_sel_o;
  logic        wb4_stall_i, wb4_ack_i;
  logic [31:0] wb4_data_i;

  pi1_to_wb4_wrbuf #(.ARCHBITSZ(32), .WRBUFDEPTH(4), .TIMEOUTCYCLES(8)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .pi1_op_i(pi1_op_i), .pi1_addr_i(pi1_addr_i), .pi1_data_i(pi1_data_i),
    .pi1_data_o(pi1_data_o), .pi1_sel_i(pi1_sel_i), .pi1_rdy_o(pi1_rdy_o),
    .wb4_cyc_o(wb4_cyc_o), .wb4_stb_o(wb4_stb_o), .wb4_we_o(wb4_we_o),
    .wb4_addr_o(wb4_addr_o), .wb4_data_o(wb4_data_o), .wb4_sel_o(wb4_sel_o),
    .wb4_stall_i(wb4_stall_i), .wb4_ack_i(wb4_ack_i), .wb4_data_i(wb4_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] rd_exp[$];

  int          checks = 0;
  int          errors = 0;

  // slave model controls
  logic        slave_en = 1'b1;
  int          ack_delay = 0;
  int          stall_left = 0;
  logic [31:0] rd_val = 32'h0;
  int          ack_count = 0;
  logic        pending = 1'b0;
  int          dly = 0;

  function automatic logic [31:0] exp_baddr(input logic [29:0] a, input logic [3:0] s);
    logic [1:0] o;
    if (s[0])      o = 2'd0;
    else if (s[1]) o = 2'd1;
    else if (s[2]) o = 2'd2;
    else if (s[3]) o = 2'd3;
    else           o = 2'd0;
    return {a, o};
  endfunction

  // Wishbone slave + beat scoreboard. Inputs change at posedge+1, beats are
  // observed at negedge.
  initial begin
    beat_t e;
    wb4_ack_i = 1'b0; wb4_stall_i = 1'b0; wb4_data_i = 32'h0;
    forever begin
      @(posedge clk); #1;
      wb4_ack_i = 1'b0; wb4_stall_i = 1'b0; wb4_data_i = 32'h0;
      if (rst_i) begin
        pending = 1'b0;
      end else begin
        if (pending && slave_en) begin
          if (dly == 0) begin
            wb4_ack_i = 1'b1; wb4_data_i = rd_val; pending = 1'b0; ack_count++;
          end else dly--;
        end
        if (wb4_cyc_o && wb4_stb_o && stall_left > 0) begin
          wb4_stall_i = 1'b1; stall_left--;
        end
      end
      @(negedge clk);
      if (!rst_i && wb4_cyc_o && wb4_stb_o && !wb4_stall_i) begin
        checks++;
        if (pending) begin
          errors++;
          $display("FAIL wb4_overlap new beat addr=%h while previous unacked, required none outstanding", wb4_addr_o);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL wb4_beat unexpected we=%b addr=%h sel=%h, required no beat", wb4_we_o, wb4_addr_o, wb4_sel_o);
        end else begin
          e = exp_q.pop_front();
          if (wb4_we_o !== e.we || wb4_addr_o !== e.addr || wb4_sel_o !== e.sel ||
              (e.we && wb4_data_o !== e.data)) begin
            errors++;
            $display("FAIL wb4_beat got we=%b addr=%h data=%h sel=%h required we=%b addr=%h data=%h sel=%h",
                     wb4_we_o, wb4_addr_o, wb4_data_o, wb4_sel_o, e.we, e.addr, e.data, e.sel);
          end
        end
        pending = 1'b1;
        dly = ack_delay;
      end
    end
  end

  // Presents one op from posedge+1 until accepted; returns at posedge+1.
  task automatic do_op(input logic [1:0] op, input logic [29:0] addr, input logic [31:0] data,
                       input logic [3:0] sel, output int waited);
    logic [31:0] er;
    beat_t b;
    waited = 0;
    pi1_op_i = op; pi1_addr_i = addr; pi1_data_i = data; pi1_sel_i = sel;
    @(negedge clk);
    while (!pi1_rdy_o && waited < 200) begin @(negedge clk); waited++; end
    checks++;
    if (!pi1_rdy_o) begin
      errors++;
      $display("FAIL pi1_handshake op=%0d rdy=%b, required 1 within 200 cycles", op, pi1_rdy_o);
    end else begin
      er = 32'h0;
      if (rd_exp.size() > 0) er = rd_exp.pop_front();
      if (pi1_data_o !== er) begin
        errors++;
        $display("FAIL pi1_data got %h required %h", pi1_data_o, er);
      end
      b.addr = exp_baddr(addr, sel); b.sel = sel; b.data = data;
      if (op == 2'b01) begin b.we = 1'b1; exp_q.push_back(b); end
      if (op[1]) begin
        b.we = 1'b0; exp_q.push_back(b);
        rd_exp.push_back(rd_val);
      end
      if (op == 2'b11) begin b.we = 1'b1; exp_q.push_back(b); end
    end
    @(posedge clk); #1;
    pi1_op_i = 2'b00;
  endtask

  task automatic wait_quiet();
    int n = 0;
    while ((exp_q.size() != 0 || wb4_cyc_o) && n < 300) begin @(negedge clk); n++; end
    checks++;
    if (exp_q.size() != 0 || wb4_cyc_o) begin
      errors++;
      $display("FAIL drain_quiet pending=%0d cyc=%b, required 0 and 0", exp_q.size(), wb4_cyc_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    pi1_op_i = 2'b01; pi1_addr_i = 30'h5; pi1_data_i = 32'hDEAD; pi1_sel_i = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({wb4_cyc_o, wb4_stb_o, wb4_we_o} !== 3'b000 || wb4_addr_o !== 32'h0 ||
        wb4_data_o !== 32'h0 || wb4_sel_o !== 4'h0) begin
      errors++;
      $display("FAIL reset_wb4 cyc=%b stb=%b we=%b addr=%h data=%h sel=%h, required all 0",
               wb4_cyc_o, wb4_stb_o, wb4_we_o, wb4_addr_o, wb4_data_o, wb4_sel_o);
    end
    checks++;
    if (pi1_rdy_o !== 1'b0 || pi1_data_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_pi1 rdy=%b data=%h, required 0 and 0", pi1_rdy_o, pi1_data_o);
    end
    @(posedge clk); #1;
    rst_i = 1'b0; pi1_op_i = 2'b00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (pi1_rdy_o !== 1'b1 || wb4_cyc_o !== 1'b0 || pi1_data_o !== 32'h0) begin
        errors++;
        $display("FAIL nop_idle rdy=%b cyc=%b data=%h, required 1 0 0", pi1_rdy_o, wb4_cyc_o, pi1_data_o);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write_mix();
    logic [3:0] sels [6];
    int w;
    sels = '{4'hF, 4'h8, 4'h6, 4'h0, 4'h4, 4'h2};
    for (int i = 0; i < 6; i++) begin
      ack_delay = i % 3;
      do_op(2'b01, 30'h200 + 30'(i), $urandom, sels[i], w);
      if (i % 2 == 1) do_op(2'b00, 30'h0, 32'h0, 4'h0, w);
    end
    wait_quiet();
    ack_delay = 0;
  endtask

  task automatic test_back_to_back();
    int w;
    int acks0;
    logic [3:0] sels [5];
    sels = '{4'hF, 4'h1, 4'h2, 4'h4, 4'h8};
    slave_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      do_op(2'b01, 30'h100 + 30'(i), 32'hA000_0000 + 32'(i), sels[i], w);
      checks++;
      if (w != 0) begin
        errors++;
        $display("FAIL b2b_accept write %0d waited %0d cycles, required 0", i, w);
      end
    end
    acks0 = ack_count;
    fork
      do_op(2'b01, 30'h104, 32'hA000_0004, sels[4], w);
      begin repeat (5) @(negedge clk); slave_en = 1'b1; end
    join
    checks++;
    if (w < 5 || ack_count == acks0) begin
      errors++;
      $display("FAIL b2b_full 5th write waited %0d acks %0d, required >=5 and >=1", w, ack_count - acks0);
    end
    wait_quiet();
  endtask

  task automatic test_read_after_write();
    int w;
    ack_delay = 2;
    rd_val = 32'hCAFE_F00D;
    do_op(2'b01, 30'h10, 32'h1122_3344, 4'hF, w);
    do_op(2'b10, 30'h10, 32'h0, 4'hF, w);
    do_op(2'b00, 30'h0, 32'h0, 4'h0, w);
    wait_quiet();
    rd_val = 32'h0BAD_BEEF;
    do_op(2'b10, 30'h33, 32'h0, 4'h2, w);
    do_op(2'b01, 30'h34, 32'h7777_8888, 4'hC, w);
    wait_quiet();
    ack_delay = 0;
  endtask

  task automatic test_rw();
    int w;
    logic started, dropped, done;
    rd_val = 32'h0000_5566;
    started = 1'b0; dropped = 1'b0; done = 1'b0;
    fork
      begin
        do_op(2'b11, 30'h8, 32'h0000_00AA, 4'h4, w);
        do_op(2'b00, 30'h0, 32'h0, 4'h0, w);
      end
      begin
        repeat (14) begin
          @(negedge clk);
          if (wb4_cyc_o) started = 1'b1;
          else if (started && !done) dropped = 1'b1;
          if (started && pi1_rdy_o) done = 1'b1;
        end
      end
    join
    checks++;
    if (!done || dropped) begin
      errors++;
      $display("FAIL rw_cyc_held done=%b dropped=%b, required 1 and 0", done, dropped);
    end
    wait_quiet();
  endtask

  task automatic test_stall();
    int w;
    int stbs;
    logic cyc_at, stb_at, seen;
    stbs = 0; seen = 1'b0; cyc_at = 1'b0; stb_at = 1'b1;
    rd_val = 32'h1357_9BDF;
    ack_delay = 2;
    stall_left = 3;
    fork
      begin
        do_op(2'b10, 30'h20, 32'h0, 4'hF, w);
        do_op(2'b00, 30'h0, 32'h0, 4'h0, w);
      end
      begin
        repeat (16) begin
          @(negedge clk);
          if (wb4_stb_o) stbs++;
          if (stbs > 0 && pi1_rdy_o && !seen) begin
            seen = 1'b1; cyc_at = wb4_cyc_o; stb_at = wb4_stb_o;
          end
        end
      end
    join
    checks++;
    if (stbs != 4) begin
      errors++;
      $display("FAIL stall_stb stb high %0d cycles, required 4", stbs);
    end
    checks++;
    if (!seen || cyc_at !== 1'b1 || stb_at !== 1'b0) begin
      errors++;
      $display("FAIL stall_ack seen=%b cyc=%b stb=%b at ack, required 1 1 0", seen, cyc_at, stb_at);
    end
    wait_quiet();
    ack_delay = 0;
    stall_left = 0;
  endtask

  task automatic test_reset_mid();
    int w;
    int n;
    logic busy;
    slave_en = 1'b0;
    for (int i = 0; i < 3; i++) do_op(2'b01, 30'h300 + 30'(i), 32'hB0B0_0000 + 32'(i), 4'hF, w);
    n = 0;
    while (!wb4_cyc_o && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(negedge clk);
    checks++;
    if (pi1_rdy_o !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_rdy rdy=%b, required 0", pi1_rdy_o);
    end
    @(negedge clk);
    checks++;
    if (wb4_cyc_o !== 1'b0 || wb4_stb_o !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_cyc cyc=%b stb=%b, required 0 0", wb4_cyc_o, wb4_stb_o);
    end
    @(posedge clk); #1;
    exp_q.delete();
    rd_exp.delete();
    rst_i = 1'b0;
    slave_en = 1'b1;
    busy = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (wb4_cyc_o || wb4_stb_o) busy = 1'b1;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL rstmid_quiet wb4 activity=%b after reset, required 0", busy);
    end
    @(posedge clk); #1;
  endtask

`ifdef PI1_TO_WB4_WRBUF_TIMEOUT_EN
  task automatic test_timeout();
    int w;
    int cycs;
    cycs = 0;
    slave_en = 1'b0;
    rd_val = 32'hFFFF_FFFF;
    fork
      begin
        do_op(2'b10, 30'h44, 32'h0, 4'hF, w);
        do_op(2'b00, 30'h0, 32'h0, 4'h0, w);
      end
      begin
        repeat (24) begin
          @(negedge clk);
          if (wb4_cyc_o) cycs++;
        end
      end
    join
    checks++;
    if (cycs != 8) begin
      errors++;
      $display("FAIL timeout_len cyc high %0d cycles, required 8", cycs);
    end
  endtask
`endif

  initial begin
    int w;
    rst_i = 1'b1;
    pi1_op_i = 2'b00; pi1_addr_i = '0; pi1_data_i = '0; pi1_sel_i = '0;
    test_reset();
    test_write_mix();
    test_back_to_back();
    test_read_after_write();
    test_rw();
    test_stall();
    test_reset_mid();
`ifdef PI1_TO_WB4_WRBUF_TIMEOUT_EN
    test_timeout();
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || rd_exp.size() != 0) begin
      errors++;
      $display("FAIL leftover beats=%0d reads=%0d, required 0 0", exp_q.size(), rd_exp.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout sim time exceeded, required completion");
    $fatal(1, "timeout");
  end

endmodule
